mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mdu_pkg.sv | 32 +++
 rtl/mul_div_unit_if.sv | 23 ++
 rtl/mdu_shift_core.sv | 54 +++++
 rtl/mul_div_unit.sv | 148 ++++++++++++++
 tb/tb_mul_div_unit.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: func3 encodings,
// FSM state type, iteration count and operand signedness helpers.
package mdu_pkg;

  localparam int ITER_COUNT = 32;
  localparam int COUNT_W    = 6;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic a_is_signed(input logic [2:0] f);
    return (f == F_MUL) || (f == F_MULH) || (f == F_MULHSU) ||
           (f == F_DIV) || (f == F_REM);
  endfunction

  function automatic logic b_is_signed(input logic [2:0] f);
    return (f == F_MUL) || (f == F_MULH) || (f == F_DIV) || (f == F_REM);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the issue stage and the multiply/divide unit.
interface mul_div_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      func3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, func3, rs1, rs2, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, func3, rs1, rs2, flush,
    output busy, done, result
  );
endinterface

// File: rtl/mdu_shift_core.sv
// Shared 64-bit accumulator: shift-add multiply (right shift) and restoring
// divide (left shift) on unsigned magnitudes, one iteration per step.
module mdu_shift_core #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic [2*XLEN-1:0] acc
);

  logic [2*XLEN-1:0] acc_reg;
  logic [XLEN-1:0]   addend_reg;
  logic              div_mode_reg;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [2*XLEN:0]   shifted;
  logic [XLEN-1:0]   trial;
  logic              fits;
  logic [2*XLEN-1:0] div_next;

  // Multiply: low half holds the multiplier, high half collects partial sums.
  assign mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} +
                    (acc_reg[0] ? {1'b0, addend_reg} : {(XLEN+1){1'b0}});
  assign mul_next = {mul_sum, acc_reg[XLEN-1:1]};

  // Divide: partial remainder may briefly need XLEN+1 bits after the shift.
  assign shifted  = {acc_reg, 1'b0};
  assign fits     = shifted[2*XLEN:XLEN] >= {1'b0, addend_reg};
  assign trial    = shifted[2*XLEN-1:XLEN] - addend_reg;
  assign div_next = fits ? {trial, shifted[XLEN-1:1], 1'b1} : shifted[2*XLEN-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg      <= '0;
      addend_reg   <= '0;
      div_mode_reg <= 1'b0;
    end else if (load) begin
      acc_reg      <= {{XLEN{1'b0}}, (is_div ? op_a : op_b)};
      addend_reg   <= is_div ? op_b : op_a;
      div_mode_reg <= is_div;
    end else if (step) begin
      acc_reg <= div_mode_reg ? div_next : mul_next;
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/mul_div_unit.sv
// RV32M multiply/divide unit: FSM, operand sign handling and result selection.
// Optional macro MDU_FAST_MUL_EN selects a single-cycle combinational multiply.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic           clk,
  input logic           rst_n,
  mul_div_unit_if.slave bus
);

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  state_e               state_reg, state_next;
  logic [COUNT_W-1:0]   count_reg;
  logic [2:0]           func3_reg;
  logic [XLEN-1:0]      rs1_reg;
  logic                 neg_a_reg, neg_b_reg;
  logic                 zero_div_reg, ovf_reg, early_reg;
  logic [XLEN-1:0]      result_reg;

  logic                 accept, step;
  logic                 in_neg_a, in_neg_b, in_is_div, in_zero_div, in_ovf, in_early;
  logic [2*XLEN-1:0]    core_acc, mul_mag, prod;
  logic [XLEN-1:0]      quo, rem, new_result;

  assign accept    = (state_reg == IDLE) && bus.start && !bus.flush;
  assign in_neg_a  = a_is_signed(bus.func3) && bus.rs1[XLEN-1];
  assign in_neg_b  = b_is_signed(bus.func3) && bus.rs2[XLEN-1];
  assign in_is_div = bus.func3[2];
  assign in_zero_div = in_is_div && (bus.rs2 == '0);
  assign in_ovf    = ((bus.func3 == F_DIV) || (bus.func3 == F_REM)) &&
                     (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2 == '1);

`ifdef MDU_FAST_MUL_EN
  logic [XLEN-1:0] rs2_reg;
  assign in_early = in_zero_div || in_ovf || !in_is_div;
`else
  assign in_early = in_zero_div || in_ovf;
`endif

  assign step = (state_reg == CALC) && !early_reg && (count_reg != COUNT_W'(ITER_COUNT));

  mdu_shift_core #(.XLEN(XLEN)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .step   (step),
    .is_div (in_is_div),
    .op_a   (magnitude(bus.rs1, in_neg_a)),
    .op_b   (magnitude(bus.rs2, in_neg_b)),
    .acc    (core_acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      func3_reg    <= '0;
      rs1_reg      <= '0;
      neg_a_reg    <= 1'b0;
      neg_b_reg    <= 1'b0;
      zero_div_reg <= 1'b0;
      ovf_reg      <= 1'b0;
      early_reg    <= 1'b0;
      result_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        count_reg    <= '0;
        func3_reg    <= bus.func3;
        rs1_reg      <= bus.rs1;
        neg_a_reg    <= in_neg_a;
        neg_b_reg    <= in_neg_b;
        zero_div_reg <= in_zero_div;
        ovf_reg      <= in_ovf;
        early_reg    <= in_early;
      end else if (step) begin
        count_reg <= count_reg + COUNT_W'(1);
      end
      if ((state_reg == DONE) && !bus.flush) begin
        result_reg <= new_result;
      end
    end
  end

`ifdef MDU_FAST_MUL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs2_reg <= '0;
    end else if (accept) begin
      rs2_reg <= bus.rs2;
    end
  end
  assign mul_mag = {{XLEN{1'b0}}, magnitude(rs1_reg, neg_a_reg)} *
                   {{XLEN{1'b0}}, magnitude(rs2_reg, neg_b_reg)};
`else
  assign mul_mag = core_acc;
`endif

  // Early-out ops still spend one cycle in CALC so results come from latched operands.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = CALC;
      CALC: begin
        if (bus.flush) begin
          state_next = IDLE;
        end else if (early_reg || (count_reg == COUNT_W'(ITER_COUNT))) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign prod = (neg_a_reg ^ neg_b_reg) ? (~mul_mag + 1'b1) : mul_mag;
  assign quo  = (neg_a_reg ^ neg_b_reg) ? (~core_acc[XLEN-1:0] + 1'b1) : core_acc[XLEN-1:0];
  assign rem  = neg_a_reg ? (~core_acc[2*XLEN-1:XLEN] + 1'b1) : core_acc[2*XLEN-1:XLEN];

  always_comb begin
    new_result = '0;
    case (func3_reg)
      F_MUL:                      new_result = prod[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU:  new_result = prod[2*XLEN-1:XLEN];
      F_DIV, F_DIVU: begin
        if (zero_div_reg)     new_result = '1;
        else if (ovf_reg)     new_result = {1'b1, {(XLEN-1){1'b0}}};
        else                  new_result = quo;
      end
      default: begin
        if (zero_div_reg)     new_result = rs1_reg;
        else if (ovf_reg)     new_result = '0;
        else                  new_result = rem;
      end
    endcase
  end

  // A flush during DONE suppresses the pulse and leaves the old result visible.
  assign bus.busy   = (state_reg != IDLE);
  assign bus.done   = (state_reg == DONE) && !bus.flush;
  assign bus.result = bus.done ? new_result : result_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: countdown reference model checked every
// cycle, plus directed vectors with hand-computed results and latencies.
module tb_mul_div_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mul_div_unit_if #(.XLEN(32)) bus ();

  mul_div_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference results straight from the RV32M arithmetic definition.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub, q;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    p  = '0;
    q  = 0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        q = sa / sb;
        return q[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        q = ua / ub;
        return q[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        q = sa % sb;
        return q[31:0];
      end
      default: begin
        if (b == 0) return a;
        q = ua % ub;
        return q[31:0];
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    if (!f[2]) return MUL_LAT;
    if (b == 0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Model: cycles remaining until idle; the last busy cycle is the done cycle.
  int          remaining;
  logic [31:0] held, pending;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= 0;
      held      <= '0;
      pending   <= '0;
    end else if (remaining > 0) begin
      if (bus.flush) begin
        remaining <= 0;
      end else begin
        if (remaining == 1) held <= pending;
        remaining <= remaining - 1;
      end
    end else if (bus.start && !bus.flush) begin
      pending   <= ref_result(bus.func3, bus.rs1, bus.rs2);
      remaining <= ref_latency(bus.func3, bus.rs1, bus.rs2) + 1;
    end
  end

  always @(negedge clk) begin
    logic exp_done;
    exp_done = (remaining == 1) && !bus.flush;
    check("cyc_busy", {31'b0, bus.busy}, {31'b0, remaining > 0});
    check("cyc_done", {31'b0, bus.done}, {31'b0, exp_done});
    check("cyc_result", bus.result, exp_done ? pending : held);
  end

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic wait_done(output int k);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (bus.busy) begin
      errors++;
      $display("FAIL %s: busy still 1 after 50 cycles, required 0", name);
    end
  endtask

  task automatic accept_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.func3 = f;
    bus.rs1   = a;
    bus.rs2   = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.func3 = 3'($urandom);
    bus.rs1   = $urandom;
    bus.rs2   = $urandom;
  endtask

  task automatic run_vec(input vec_t v);
    int k;
    logic [31:0] r;
    accept_op(v.f, v.a, v.b);
    wait_done(k);
    r = bus.result;
    $display("op f=%0d a=%h b=%h result=%h done_after=E%0d", v.f, v.a, v.b, r, k);
    check("latency", k, v.lat);
    check("result", r, v.res);
    wait_idle("idle_after_op");
    @(posedge clk);
    #1;
    check("result_held", bus.result, v.res);
  endtask

  initial begin
    int k;
    logic [31:0] prev;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.func3 = '0;
    bus.rs1   = '0;
    bus.rs2   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'b0, bus.busy}, 32'd0);
    check("reset_done", {31'b0, bus.done}, 32'd0);
    check("reset_result", bus.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back('{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT});
    vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT});
    vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT});
    vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, MUL_LAT});
    vecs.push_back('{3'd0, 32'h1234_5678, 32'h10,        32'h2345_6780, MUL_LAT});
    vecs.push_back('{3'd3, 32'h8000_0000, 32'd4,         32'h0000_0002, MUL_LAT});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33});
    vecs.push_back('{3'd5, 32'd100,       32'd7,         32'd14,        33});
    vecs.push_back('{3'd7, 32'd100,       32'd7,         32'd2,         33});
    vecs.push_back('{3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33});
    vecs.push_back('{3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         33});
    vecs.push_back('{3'd5, 32'd100,       32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{3'd7, 32'd100,       32'd0,         32'd100,       1});
    vecs.push_back('{3'd4, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{3'd6, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 1});
    vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
    vecs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1});
    vecs.push_back('{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33});
    vecs.push_back('{3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33});

    foreach (vecs[i]) run_vec(vecs[i]);

    // Ignored restart at E5, flush sampled at E11: no done, result retained.
    prev = bus.result;
    accept_op(3'd5, 32'd1000, 32'd3);
    for (int e = 1; e <= 10; e++) begin
      if (e == 5) begin
        bus.start = 1'b1;
        bus.func3 = 3'd0;
        bus.rs1   = 32'd5;
        bus.rs2   = 32'd5;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (e == 5) check("busy_after_restart", {31'b0, bus.busy}, 32'd1);
    end
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    $display("op flush divu busy=%0d result=%h", bus.busy, bus.result);
    check("flush_busy", {31'b0, bus.busy}, 32'd0);
    check("flush_result", bus.result, prev);
    wait_done(k);
    check("flush_no_done", k, 0);
    check("flush_result_later", bus.result, prev);

    // Start and flush together in IDLE: not accepted.
    @(negedge clk);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.func3 = 3'd5;
    bus.rs1   = 32'd9;
    bus.rs2   = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    $display("op start+flush busy=%0d", bus.busy);
    check("start_flush_busy", {31'b0, bus.busy}, 32'd0);

    // Reset at E20 of an active DIV.
    accept_op(3'd4, 32'd1000, 32'd7);
    repeat (19) @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    $display("op reset busy=%0d done=%0d result=%h", bus.busy, bus.done, bus.result);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(k);
    check("rst_no_done", k, 0);
    run_vec('{3'd4, 32'd1000, 32'd7, 32'd142, 33});

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, limit 500000", $time);
    $fatal(1, "timeout");
  end

endmodule
